// File: rtl/aes_pkg.sv
// Shared AES types and byte/word helpers used by the key schedule and the round datapath.
package aes_pkg;

  localparam int KEY_W          = 128;
  localparam int WORD_W         = 32;
  localparam int NUM_ROUNDS_128 = 10;

  typedef logic [7:0]        byte_t;
  typedef logic [WORD_W-1:0] word_t;

  // Forward S-box, entry 0 in the leftmost byte.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox(input byte_t b);
    return SBOX_TABLE[b];
  endfunction

  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box; shared by the key schedule and SubBytes.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] subst
);

  assign subst = sbox(data);

endmodule

// File: rtl/key_schedule.sv
// On-the-fly AES-128 round-key generator: load a cipher key, then advance one round key per enable.
module key_schedule
  import aes_pkg::*;
#(
  parameter logic [127:0] RESET_KEY  = 128'h0,
  parameter int           NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [127:0] key_in,
  input  logic         enable,
  output logic [127:0] round_key,
  output logic [3:0]   rk_index,
  output logic [7:0]   rcon,
  output logic         exhausted
);

  if (NUM_ROUNDS != NUM_ROUNDS_128) begin : g_bad_rounds
    $error("key_schedule supports only NUM_ROUNDS = 10");
  end

  word_t w0, w1, w2, w3;
  word_t rot, sub, t;
  word_t n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = round_key;
  assign rot = rot_word(w3);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .data  (rot[8*i +: 8]),
      .subst (sub[8*i +: 8])
    );
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign exhausted = (rk_index == 4'(NUM_ROUNDS));

  // Load wins over enable: the controller pulses enable on the load cycle too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_key <= RESET_KEY;
      rk_index  <= 4'd0;
      rcon      <= 8'h01;
    end else if (load) begin
      round_key <= key_in;
      rk_index  <= 4'd0;
      rcon      <= 8'h01;
    end else if (enable && !exhausted) begin
      round_key <= {n0, n1, n2, n3};
      rk_index  <= rk_index + 4'd1;
      rcon      <= xtime(rcon);
    end
  end

endmodule

// File: doc/key_schedule.md
Name: key_schedule

Overview:
On-the-fly AES-128 round-key generator for the fine multicycle core.
- Loads a 128-bit cipher key when the controller samples a new block.
- Each time the controller pulses its key-schedule enable, the block advances one round key.
- The current round key is presented from a register to the round datapath.
- It sits beside the controller: it consumes the controller's input-register strobe and key-schedule enable, and feeds the AddRoundKey stage.

Parameters:
- RESET_KEY, 128'h0, value loaded into the key register on reset.
- NUM_ROUNDS, 10, number of round-key advances after a load. Only 10 (AES-128) is supported; any other value is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  sample key_in this edge; driven from the controller's input-register strobe
- key_in  in  128  cipher key, word 0 in bits [127:96]
- enable  in  1  advance to the next round key this edge; driven from the controller's key-schedule enable
- round_key  out  128  current round key (registered)
- rk_index  out  4  index of round_key, 0 = cipher key, 10 = final round key
- rcon  out  8  rcon to be used by the next advance (registered; exposed for debug)
- exhausted  out  1  high when rk_index == NUM_ROUNDS

Behaviour:
Reset (rst_n low, asynchronous):
- round_key = RESET_KEY, rk_index = 0, rcon = 8'h01, exhausted = 0.
- A reset mid-expansion discards all progress.

Priority per rising edge: load > enable > hold.
- load = 1: round_key <= key_in, rk_index <= 0, rcon <= 8'h01.
  - enable in the same cycle is ignored.
  - A load mid-expansion restarts cleanly from the new key.
- load = 0, enable = 1, rk_index < NUM_ROUNDS: round_key <= next_key(round_key, rcon), rk_index <= rk_index + 1, rcon <= xtime(rcon).
- load = 0, enable = 1, rk_index == NUM_ROUNDS: no state change. The key saturates; there is no wrap to index 0 and no error flag.
- Otherwise all registers hold.

next_key computation:
- Split round_key into words w0..w3 (w0 = [127:96]).
- t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}, where RotWord({a,b,c,d}) = {b,c,d,a} and SubWord applies the AES S-box per byte.
- n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.

rcon arithmetic:
- xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
- Sequence: 01,02,04,08,10,20,40,80,1B,36.
- rcon after index 10 is don't-care but must be deterministic (xtime of 36 = 6C).

Latency and timing:
- round_key, rk_index and exhausted update on the edge where load or enable is sampled, and are visible the following cycle.
- next_key is a single combinational cycle (4 S-boxes plus XOR chain), registered once.
- exhausted is derived combinationally from the registered rk_index; it has no extra state.

Integration with the controller:
- The controller asserts enable once per round at step 0, including the load cycle.
- Load priority is therefore required: the load cycle yields index 0, and the following ten enables yield indices 1..10.

Decomposition:
- Shared package aes_pkg holds:
  - KEY_W = 128, WORD_W = 32, NUM_ROUNDS_128 = 10;
  - the byte_t and word_t typedefs;
  - the functions xtime, rot_word and sub_word.
- sub_word instantiates no state and calls the S-box.
- One sub-module: aes_sbox (8-bit combinational S-box lookup), instantiated 4 times for SubWord. It is shared with the round datapath's SubBytes.

Test Plan:
1. Reset, then load key 2b7e151628aed2a6abf7158809cf4f3c -> next cycle round_key equals the key, rk_index = 0, rcon = 01.
2. From step 1, one enable -> round_key a0fafe1788542cb123a339392a6c7605, rk_index = 1, rcon = 02. A second enable -> f2c295f27a96b9435935807a7359f67f.
3. From step 1, ten enables (gaps of 2 idle cycles between them, matching controller pacing) -> round_key d014f9a8c9ee2589e13f0cc8b6630ca6, rk_index = 10, exhausted = 1. Two further enables -> all outputs unchanged.
4. load and enable high in the same cycle with key 000102030405060708090a0b0c0d0e0f -> round_key = that key, rk_index = 0 (enable ignored). One enable -> d6aa74fdd2af72fadaa678f1d6ab76fe.
5. After 5 enables, load a new key -> rk_index = 0 and rcon = 01. Ten enables then reproduce that key's round-10 value exactly.
6. Drop rst_n asynchronously mid-expansion (between clock edges) -> outputs go to RESET_KEY / 0 / 01 / 0 immediately. Enable held high during reset has no effect.
